// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   General-purpose integer register file for the processor datapath.
//   Two combinational read ports feed the ALU operands and one synchronous
//   write port takes the writeback result. Register 0 is hardwired to zero.
//
// Parameters
//   WIDTH  data width of each register, in bits
//   DEPTH  number of registers
//   AW     address width, derived from DEPTH
//
// Ports
//   clk         in   1      system clock, writes on rising edge
//   rst         in   1      asynchronous active-low reset, clears every register
//   REGWRITE    in   1      write enable, sampled at posedge clk
//   ADR_REG1    in   AW     read port 1 address
//   ADR_REG2    in   AW     read port 2 address
//   ADR_WR_REG  in   AW     write address
//   WR_DATA     in   WIDTH  write data
//   REG_DATA1   out  WIDTH  read port 1 data (combinational)
//   REG_DATA2   out  WIDTH  read port 2 data (combinational)
// ---------------------------------------------------------------------------
module register_file #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             REGWRITE,
    input  logic [AW-1:0]    ADR_REG1,
    input  logic [AW-1:0]    ADR_REG2,
    input  logic [AW-1:0]    ADR_WR_REG,
    input  logic [WIDTH-1:0] WR_DATA,
    output logic [WIDTH-1:0] REG_DATA1,
    output logic [WIDTH-1:0] REG_DATA2
);

    // Every code the address bus can carry gets a slot in the read table, so
    // out-of-range addresses (non power-of-two DEPTH) simply select a zero.
    localparam int NSLOT = 1 << AW;

    // Register 0 has no storage at all; only indices 1..DEPTH-1 are flops.
    logic [WIDTH-1:0] regs_q [1:DEPTH-1];
    logic [WIDTH-1:0] regs_d [1:DEPTH-1];
    logic [WIDTH-1:0] rd_tbl [NSLOT];

    // Write decode: the compare against each real index means address 0 and
    // any out-of-range address match nothing, so such writes fall away.
    always_comb begin
        for (int i = 1; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (REGWRITE && (ADR_WR_REG == AW'(i))) begin
                regs_d[i] = WR_DATA;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read table: slot 0 and unbacked slots read as zero. No write bypass, so
    // a same-cycle read of the write target returns the pre-edge value.
    always_comb begin
        for (int j = 0; j < NSLOT; j++) begin
            rd_tbl[j] = '0;
        end
        for (int i = 1; i < DEPTH; i++) begin
            rd_tbl[i] = regs_q[i];
        end
    end

    assign REG_DATA1 = rd_tbl[ADR_REG1];
    assign REG_DATA2 = rd_tbl[ADR_REG2];

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic             clk;
    logic             rst;
    logic             REGWRITE;
    logic [AW-1:0]    ADR_REG1;
    logic [AW-1:0]    ADR_REG2;
    logic [AW-1:0]    ADR_WR_REG;
    logic [WIDTH-1:0] WR_DATA;
    logic [WIDTH-1:0] REG_DATA1;
    logic [WIDTH-1:0] REG_DATA2;

    int n_cmp = 0;
    int n_bad = 0;

    register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .REGWRITE   (REGWRITE),
        .ADR_REG1   (ADR_REG1),
        .ADR_REG2   (ADR_REG2),
        .ADR_WR_REG (ADR_WR_REG),
        .WR_DATA    (WR_DATA),
        .REG_DATA1  (REG_DATA1),
        .REG_DATA2  (REG_DATA2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic             we;
        logic [AW-1:0]    wa;
        logic [WIDTH-1:0] wd;
        logic [AW-1:0]    a1;
        logic [AW-1:0]    a2;
        logic [WIDTH-1:0] e1;
        logic [WIDTH-1:0] e2;
        string            name;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Expected contents after each vector, computed by hand from the
        // sequence of writes (registers start at zero after reset).
        vecs[0] = '{1'b1, 5'd1,  32'hDEADBEEF, 5'd1,  5'd0,  32'hDEADBEEF, 32'h00000000, "wr_r1"};
        vecs[1] = '{1'b1, 5'd2,  32'h12345678, 5'd2,  5'd1,  32'h12345678, 32'hDEADBEEF, "wr_r2"};
        vecs[2] = '{1'b1, 5'd3,  32'h87654321, 5'd2,  5'd3,  32'h12345678, 32'h87654321, "dual_read"};
        vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000, "r0_protect"};
        vecs[4] = '{1'b0, 5'd4,  32'hA5A5A5A5, 5'd4,  5'd3,  32'h00000000, 32'h87654321, "we_low"};
        vecs[5] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, "top_both"};
        vecs[6] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd2,  32'h00000001, 32'h12345678, "overwrite"};
        vecs[7] = '{1'b0, 5'd1,  32'hFFFF0000, 5'd1,  5'd30, 32'h00000001, 32'h00000000, "hold_r1"};
        vecs[8] = '{1'b1, 5'd30, 32'h5555AAAA, 5'd30, 5'd0,  32'h5555AAAA, 32'h00000000, "wr_r30"};

        rst        = 1'b0;
        REGWRITE   = 1'b0;
        ADR_REG1   = '0;
        ADR_REG2   = '0;
        ADR_WR_REG = '0;
        WR_DATA    = '0;

        // Reset state at several addresses while reset is held.
        for (int a = 0; a < DEPTH; a += 7) begin
            ADR_REG1 = AW'(a);
            ADR_REG2 = AW'(DEPTH - 1 - a);
            #1;
            check("reset_rd1", REG_DATA1, 32'h0);
            check("reset_rd2", REG_DATA2, 32'h0);
        end
        tick();
        rst = 1'b1;

        // Table-driven write/read sequence.
        foreach (vecs[k]) begin
            REGWRITE   = vecs[k].we;
            ADR_WR_REG = vecs[k].wa;
            WR_DATA    = vecs[k].wd;
            ADR_REG1   = vecs[k].a1;
            ADR_REG2   = vecs[k].a2;
            tick();
            check({vecs[k].name, "_p1"}, REG_DATA1, vecs[k].e1);
            check({vecs[k].name, "_p2"}, REG_DATA2, vecs[k].e2);
        end
        REGWRITE = 1'b0;

        // Reads follow an address change with no clock edge.
        ADR_REG1 = 5'd31;
        ADR_REG2 = 5'd3;
        #1;
        check("comb_addr_p1", REG_DATA1, 32'hCAFEF00D);
        check("comb_addr_p2", REG_DATA2, 32'h87654321);

        // Same-cycle write/read of r5: old value before the edge, new after.
        REGWRITE   = 1'b1;
        ADR_WR_REG = 5'd5;
        WR_DATA    = 32'h0BADCAFE;
        ADR_REG1   = 5'd5;
        ADR_REG2   = 5'd5;
        #1;
        check("r5_before_edge", REG_DATA1, 32'h00000000);
        tick();
        check("r5_after_p1", REG_DATA1, 32'h0BADCAFE);
        check("r5_after_p2", REG_DATA2, 32'h0BADCAFE);
        REGWRITE = 1'b0;

        // Asynchronous reset mid-cycle clears without an edge.
        ADR_REG1 = 5'd1;
        ADR_REG2 = 5'd31;
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_p1", REG_DATA1, 32'h0);
        check("async_rst_p2", REG_DATA2, 32'h0);

        // Reset overrides a write presented during reset.
        REGWRITE   = 1'b1;
        ADR_WR_REG = 5'd6;
        WR_DATA    = 32'h13579BDF;
        ADR_REG1   = 5'd6;
        tick();
        check("rst_over_wr", REG_DATA1, 32'h0);
        REGWRITE = 1'b0;
        rst = 1'b1;

        // After release, previously written registers stay cleared.
        ADR_REG1 = 5'd1;
        ADR_REG2 = 5'd2;
        #1;
        check("post_rst_r1", REG_DATA1, 32'h0);
        check("post_rst_r2", REG_DATA2, 32'h0);

        // Writes work again after reset.
        REGWRITE   = 1'b1;
        ADR_WR_REG = 5'd7;
        WR_DATA    = 32'h2468ACE0;
        ADR_REG1   = 5'd7;
        ADR_REG2   = 5'd6;
        tick();
        REGWRITE = 1'b0;
        check("post_rst_wr_r7", REG_DATA1, 32'h2468ACE0);
        check("post_rst_r6", REG_DATA2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
